// File: rtl/pwm_compare.sv
// PWM comparator: compares a shared free-running counter against a duty
// threshold, with a one-deep duty holding register that is applied only at
// period boundaries, and a small IDLE/ARMED/RUN/DRAIN run-control FSM.
module pwm_compare #(
  parameter int unsigned N = 7
) (
  input  logic         clock,
  input  logic         clear,
  input  logic [0:N]   count,
  input  logic         enable,
  input  logic [0:N]   duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic         pwm,
  output logic         period_done,
  output logic [7:0]   period_cnt,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    RUN   = 2'b10,
    DRAIN = 2'b11
  } state_t;

  state_t     st;
  state_t     st_next;
  logic [0:N] prev_count;
  logic [0:N] pend_duty;
  logic [0:N] active_duty;
  logic [0:N] eff_duty;
  logic       pending;
  logic       boundary;
  logic       apply;
  logic       accept;
  logic       running;
  logic       running_next;

  // Boundary detection, duty handshake qualifiers and effective threshold
  always_comb begin
    boundary     = (count == '0) && (prev_count != '0);
    apply        = boundary && pending;
    accept       = duty_valid && !pending;
    eff_duty     = apply ? pend_duty : active_duty;
    running      = (st == RUN) || (st == DRAIN);
    running_next = (st_next == RUN) || (st_next == DRAIN);
  end

  // Run-control next state; dropping enable wins over a coincident boundary
  always_comb begin
    st_next = st;
    unique case (st)
      IDLE:    if (enable) st_next = ARMED;
      ARMED: begin
        if (!enable)       st_next = IDLE;
        else if (boundary) st_next = RUN;
      end
      RUN:     if (!enable) st_next = DRAIN;
      DRAIN: begin
        if (enable)        st_next = RUN;
        else if (boundary) st_next = IDLE;
      end
      default: st_next = IDLE;
    endcase
  end

  // State register and counter history
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      st         <= IDLE;
      prev_count <= '1;
    end else begin
      st         <= st_next;
      prev_count <= count;
    end
  end

  // Duty holding register: accept when empty, promote to active at a boundary
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pend_duty   <= '0;
      active_duty <= '0;
      pending     <= 1'b0;
    end else if (apply) begin
      active_duty <= pend_duty;
      pending     <= 1'b0;
    end else if (accept) begin
      pend_duty   <= duty_in;
      pending     <= 1'b1;
    end
  end

  // Registered waveform and period bookkeeping
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pwm         <= 1'b0;
      period_done <= 1'b0;
      period_cnt  <= '0;
    end else begin
      pwm         <= running_next && (count < eff_duty);
      period_done <= boundary && running;
      if (boundary && running) period_cnt <= period_cnt + 8'd1;
    end
  end

  assign duty_ready = ~pending;
  assign state      = st;

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare with a cycle-level reference model and
// hand-computed per-period expectations.
module tb_pwm_compare;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       duty_valid = 1'b0;
  logic [7:0] duty_in = 8'd0;
  logic [7:0] cnt;
  logic       duty_ready;
  logic       pwm;
  logic       period_done;
  logic [7:0] period_cnt;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Upstream free-running counter sharing clock and clear
  always @(posedge clock or posedge clear) begin
    if (clear) cnt <= 8'd0;
    else       cnt <= cnt + 8'd1;
  end

  pwm_compare #(.N(7)) dut (
    .clock       (clock),
    .clear       (clear),
    .count       (cnt),
    .enable      (enable),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm         (pwm),
    .period_done (period_done),
    .period_cnt  (period_cnt),
    .state       (state)
  );

  // Reference model: mode 0 idle, 1 armed, 2 run, 3 drain; queued = -1 when empty
  int m_mode, m_cur, m_queued, m_last, m_periods;
  bit m_pwm, m_pd;
  bit m_b;
  int m_nm, m_d;

  always_comb begin
    m_b = (int'(cnt) == 0) && (m_last != 0);
    m_d = (m_b && m_queued >= 0) ? m_queued : m_cur;
    m_nm = m_mode;
    case (m_mode)
      0: if (enable) m_nm = 1;
      1: if (!enable) m_nm = 0; else if (m_b) m_nm = 2;
      2: if (!enable) m_nm = 3;
      default: if (enable) m_nm = 2; else if (m_b) m_nm = 0;
    endcase
  end

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      m_mode <= 0; m_cur <= 0; m_queued <= -1; m_last <= 255;
      m_periods <= 0; m_pwm <= 1'b0; m_pd <= 1'b0;
    end else begin
      m_mode <= m_nm;
      m_last <= int'(cnt);
      m_pwm  <= (m_nm >= 2) && (int'(cnt) < m_d);
      m_pd   <= m_b && (m_mode >= 2);
      if (m_b && m_mode >= 2) m_periods <= (m_periods + 1) % 256;
      if (m_b && m_queued >= 0) begin
        m_cur    <= m_queued;
        m_queued <= -1;
      end else if (duty_valid && m_queued < 0) begin
        m_queued <= int'(duty_in);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if ($time > 5) begin
      check("model_pwm", int'(pwm), int'(m_pwm));
      check("model_period_done", int'(period_done), int'(m_pd));
      check("model_period_cnt", int'(period_cnt), m_periods);
      check("model_state", int'(state), m_mode);
      check("model_duty_ready", int'(duty_ready), (m_queued < 0) ? 1 : 0);
    end
  end

  task automatic wait_cnt(input int v);
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      if (int'(cnt) == v) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_cnt: timeout waiting for count %0d at %0t", v, $time);
  endtask

  task automatic offer(input int v);
    duty_in    = 8'(v);
    duty_valid = 1'b1;
    @(negedge clock);
    duty_valid = 1'b0;
  endtask

  // Sums pwm and period_done over 256 consecutive samples starting now
  task automatic measure(output int highs, output int pds);
    highs = 0;
    pds   = 0;
    for (int i = 0; i < 256; i++) begin
      highs += int'(pwm);
      pds   += int'(period_done);
      @(negedge clock);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_pwm"}, int'(pwm), 0);
    check({tag, "_period_done"}, int'(period_done), 0);
    check({tag, "_period_cnt"}, int'(period_cnt), 0);
    check({tag, "_duty_ready"}, int'(duty_ready), 1);
  endtask

  int h, p, hsum, psum;

  initial begin
    #1 clear = 1'b1;
    #3 check_reset_values("reset");
    repeat (3) @(negedge clock);
    clear = 1'b0;

    // Duty 64 loaded in IDLE, then enable
    offer(64);
    check("load64_ready", int'(duty_ready), 0);
    enable = 1'b1;
    @(negedge clock);
    check("armed_state", int'(state), 1);
    wait_cnt(1);
    check("run_entry_state", int'(state), 2);
    measure(h, p);
    check("duty64_p1_highs", h, 64);
    check("duty64_p1_period_done", p, 0);
    measure(h, p);
    check("duty64_p2_highs", h, 64);
    check("duty64_p2_period_done", p, 1);
    check("period_cnt_after_two", int'(period_cnt), 2);

    // Handshake: 128 accepted, 32 ignored while busy
    wait_cnt(50);
    check("hs_ready_before", int'(duty_ready), 1);
    offer(128);
    check("hs_ready_busy", int'(duty_ready), 0);
    wait_cnt(60);
    offer(32);
    wait_cnt(0);
    check("hs_ready_at_boundary", int'(duty_ready), 0);
    @(negedge clock);
    check("hs_ready_after", int'(duty_ready), 1);
    measure(h, p);
    check("duty128_highs", h, 128);
    check("duty128_period_done", p, 1);

    // Extremes
    wait_cnt(10);
    offer(0);
    wait_cnt(1);
    measure(h, p);
    check("duty0_highs", h, 0);
    wait_cnt(10);
    offer(255);
    wait_cnt(1);
    measure(h, p);
    check("duty255_highs", h, 255);
    wait_cnt(255);
    check("duty255_high_at_254", int'(pwm), 1);

    // Accept coincident with boundary: old duty this period, 200 next
    wait_cnt(0);
    check("duty255_low_after_max", int'(pwm), 0);
    duty_in    = 8'd200;
    duty_valid = 1'b1;
    @(negedge clock);
    duty_valid = 1'b0;
    check("coincident_ready", int'(duty_ready), 0);
    measure(h, p);
    check("coincident_old_highs", h, 255);
    measure(h, p);
    check("coincident_new_highs", h, 200);

    // Enable dropped mid-period: drain to the boundary, then idle
    wait_cnt(100);
    enable = 1'b0;
    @(negedge clock);
    check("drain_state", int'(state), 3);
    wait_cnt(0);
    check("drain_state_end", int'(state), 3);
    @(negedge clock);
    check("drain_period_done", int'(period_done), 1);
    check("drain_to_idle", int'(state), 0);
    hsum = 0;
    psum = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      hsum += int'(pwm);
      psum += int'(period_done);
    end
    check("idle_pwm_highs", hsum, 0);
    check("idle_period_done", psum, 0);

    // Clear mid-period with a pending duty
    enable = 1'b1;
    wait_cnt(1);
    check("rerun_state", int'(state), 2);
    wait_cnt(20);
    offer(16);
    check("pending16_ready", int'(duty_ready), 0);
    wait_cnt(150);
    #2 clear = 1'b1;
    #1 check_reset_values("midclear");
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check("postclear_armed", int'(state), 1);
    wait_cnt(1);
    check("postclear_run", int'(state), 2);
    measure(h, p);
    check("postclear_highs", h, 0);
    check("postclear_period_done", p, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_compare.md
PWM_COMPARE -- requirements
Module: pwm_compare

Interface
REQ-001 Parameter N: default 7; the count bus is N+1 bits wide.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 clear  input  1  reset; asynchronous, active-high.
REQ-004 count  input  [0:N]  free-running counter value, bit 0 = MSB; driven by the same clock and clear.
REQ-005 enable  input  1  level request to run the PWM.
REQ-006 duty_in  input  [0:N]  new duty threshold.
REQ-007 duty_valid  input  1  duty_in is valid this cycle.
REQ-008 duty_ready  output  1  block can accept duty_in; equals NOT pending.
REQ-009 pwm  output  1  registered PWM waveform.
REQ-010 period_done  output  1  one-cycle pulse at each period boundary while running.
REQ-011 period_cnt  output  8  number of completed periods while running; wraps 255 -> 0.
REQ-012 state  output  2  FSM state: 00 IDLE, 01 ARMED, 10 RUN, 11 DRAIN.

Function
REQ-013 prev_count SHALL register count every cycle.
REQ-014 boundary SHALL be combinational: count == 0 AND prev_count != 0.
REQ-015 The block SHALL accept a duty value on any cycle where duty_valid AND duty_ready are both high.
  - pend_duty <= duty_in
  - pending <= 1
REQ-016 On boundary with pending = 1 (the value registered at the start of the cycle):
  - active_duty <= pend_duty
  - pending <= 0
REQ-017 When a duty accept and a boundary occur in the same cycle with pending = 0, the accepted value SHALL become pending and apply at the next boundary.
REQ-018 duty_valid while duty_ready = 0 SHALL be ignored; pend_duty is not overwritten.
REQ-019 FSM transitions:
  - IDLE -> ARMED when enable = 1.
  - ARMED -> RUN on boundary.
  - ARMED -> IDLE if enable = 0 before a boundary.
  - RUN -> DRAIN when enable = 0.
  - DRAIN -> IDLE on boundary.
  - DRAIN -> RUN if enable = 1 again before that boundary.
REQ-020 pwm SHALL be registered with 1-cycle latency.
  - pwm <= 1 when next-state is RUN or DRAIN and count < eff_duty.
  - Otherwise pwm <= 0.
  - eff_duty = pend_duty on a boundary cycle with pending = 1; else active_duty.
REQ-021 Comparison is unsigned, N+1 bits.
  - duty = 0: pwm is constantly 0.
  - duty = 2^(N+1)-1: pwm is 0 only for count = max.
REQ-022 period_done SHALL be registered: period_done <= boundary AND state in {RUN, DRAIN}.
REQ-023 period_cnt SHALL increment on the same condition as period_done, wrapping modulo 256.
REQ-024 The entering ARMED -> RUN boundary SHALL NOT pulse period_done.
REQ-025 A count discontinuity to 0 (upstream clear mid-period) SHALL be treated as a boundary.

Reset
REQ-026 While clear = 1, regardless of clock, the block SHALL hold:
  - state = IDLE
  - pwm = 0, period_done = 0, period_cnt = 0
  - active_duty = 0, pend_duty = 0, pending = 0 (so duty_ready = 1)
  - prev_count = all ones
REQ-027 With prev_count reset to all ones, the first post-reset cycle with count = 0 SHALL be a boundary.
REQ-028 Assertion of clear mid-period SHALL abort immediately and discard any pending duty.

Verification (N = 7, counter wraps 255 -> 0)
REQ-029 Reset then enable, duty 64 loaded in IDLE:
  - RUN entered at the first boundary.
  - pwm is high for exactly 64 of every 256 cycles.
  - period_done pulses every 256 cycles.
REQ-030 Duty handshake:
  - Accept 128 mid-period, then offer 32 while duty_ready = 0: 32 is ignored.
  - Next period is 128 high cycles; duty_ready returns to 1 one cycle after that boundary.
REQ-031 Extremes:
  - duty 0: pwm always 0.
  - duty 255: pwm is low only in the cycle following count = 255.
REQ-032 enable dropped at count = 100 in RUN:
  - state goes to DRAIN; the period completes.
  - One period_done pulse, then IDLE; pwm stays 0 afterwards.
REQ-033 clear asserted at count = 150 with a duty pending:
  - All outputs go to reset values asynchronously.
  - After release with count = 0 and enable = 1: a boundary is detected, RUN is entered, and the old duty is not applied.
REQ-034 Accept and boundary in the same cycle (accept 200 with count = 0):
  - The current period uses the old duty.
  - The following period uses 200.
